// File: rtl/riscv_defines.sv
// Shared core definitions: address width, LSU access sizes and LSU FSM states.
package riscv_defines;

  localparam int RISCV_ADDR_WIDTH = 32;

  localparam logic [1:0] LSU_SIZE_B = 2'b00;
  localparam logic [1:0] LSU_SIZE_H = 2'b01;
  localparam logic [1:0] LSU_SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } lsu_state_e;

endpackage

// File: rtl/lsu_data_align.sv
// Combinational lane logic: byte enables, split detection, store-data rotation,
// and load-data extraction with sign/zero extension.
module lsu_data_align
  import riscv_defines::*;
(
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  input  logic [31:0] lo,
  output logic [7:0]  be8,
  output logic        split,
  output logic [31:0] wdata_rot,
  output logic [31:0] rdata_ext
);

  logic [3:0]  mask;
  logic [63:0] word;
  logic [31:0] raw;

  function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic sgn);
    logic signed [7:0] sb;
    sb = signed'(b);
    return sgn ? 32'(sb) : {24'b0, b};
  endfunction

  function automatic logic [31:0] ext_half(input logic [15:0] h, input logic sgn);
    logic signed [15:0] sh;
    sh = signed'(h);
    return sgn ? 32'(sh) : {16'b0, h};
  endfunction

  always_comb begin
    mask      = 4'b1111;
    wdata_rot = wdata;
    rdata_ext = 32'b0;
    case (size)
      LSU_SIZE_B: mask = 4'b0001;
      LSU_SIZE_H: mask = 4'b0011;
      default:    mask = 4'b1111;
    endcase
    be8   = {4'b0, mask} << off;
    split = |be8[7:4];

    case (off)
      2'd0:    wdata_rot = wdata;
      2'd1:    wdata_rot = {wdata[23:0], wdata[31:24]};
      2'd2:    wdata_rot = {wdata[15:0], wdata[31:16]};
      default: wdata_rot = {wdata[7:0],  wdata[31:8]};
    endcase

    // A split load has its low bytes in the upper lanes of the first word.
    word = split ? {rdata, lo} : {32'b0, rdata};
    raw  = 32'(word >> {off, 3'b000});
    case (size)
      LSU_SIZE_B: rdata_ext = ext_byte(raw[7:0], sign_ext);
      LSU_SIZE_H: rdata_ext = ext_half(raw[15:0], sign_ext);
      default:    rdata_ext = raw;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-side LSU: single-outstanding req/gnt/rvalid transactions, misaligned
// accesses split into two word transfers, load data extended for the register file.
module load_store_unit
  import riscv_defines::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = RISCV_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  lsu_en_i,
  input  logic                  lsu_we_i,
  input  logic [1:0]            lsu_size_i,
  input  logic                  lsu_sign_ext_i,
  input  logic [ADDR_WIDTH-1:0] lsu_addr_i,
  input  logic [DATA_WIDTH-1:0] lsu_wdata_i,
  output logic [DATA_WIDTH-1:0] lsu_rdata_o,
  output logic                  lsu_done_o,
  output logic                  data_req_o,
  input  logic                  data_gnt_i,
  output logic [ADDR_WIDTH-1:0] data_addr_o,
  output logic                  data_we_o,
  output logic [3:0]            data_be_o,
  output logic [DATA_WIDTH-1:0] data_wdata_o,
  input  logic                  data_rvalid_i,
  input  logic [DATA_WIDTH-1:0] data_rdata_i
);

  lsu_state_e            state;
  logic                  second_q;
  logic [31:0]           lo_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  we_q;
  logic [1:0]            size_q;
  logic                  sign_q;
  logic [31:0]           wdata_q;

  logic                  issue;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic                  cur_we;
  logic [1:0]            cur_size;
  logic                  cur_sign;
  logic [31:0]           cur_wdata;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic [7:0]            be8;
  logic                  split;
  logic [31:0]           wdata_rot;
  logic [31:0]           rdata_ext;
  logic                  last_resp;

  // Operands come straight from the controller in the issue cycle and from the
  // latched copy afterwards, so the bus stays stable even if lsu_en_i drops.
  assign issue     = (state == IDLE) && lsu_en_i;
  assign cur_addr  = (state == IDLE) ? lsu_addr_i     : addr_q;
  assign cur_we    = (state == IDLE) ? lsu_we_i       : we_q;
  assign cur_size  = (state == IDLE) ? lsu_size_i     : size_q;
  assign cur_sign  = (state == IDLE) ? lsu_sign_ext_i : sign_q;
  assign cur_wdata = (state == IDLE) ? lsu_wdata_i    : wdata_q;
  assign word_addr = {cur_addr[ADDR_WIDTH-1:2], 2'b00};

  lsu_data_align u_align (
    .off       (cur_addr[1:0]),
    .size      (cur_size),
    .sign_ext  (cur_sign),
    .wdata     (cur_wdata),
    .rdata     (data_rdata_i),
    .lo        (lo_q),
    .be8       (be8),
    .split     (split),
    .wdata_rot (wdata_rot),
    .rdata_ext (rdata_ext)
  );

  assign last_resp    = !(split && !second_q);
  assign data_req_o   = rst_n && (issue || (state == REQ));
  assign lsu_done_o   = (state == RESP) && data_rvalid_i && last_resp;
  assign lsu_rdata_o  = (lsu_done_o && !cur_we) ? rdata_ext : '0;
  assign data_addr_o  = !data_req_o ? '0 :
                        second_q ? word_addr + ADDR_WIDTH'(4) : word_addr;
  assign data_be_o    = !data_req_o ? 4'b0 : (second_q ? be8[7:4] : be8[3:0]);
  assign data_we_o    = data_req_o && cur_we;
  assign data_wdata_o = data_req_o ? wdata_rot : '0;

  always_ff @(posedge clk) begin
    if (issue) begin
      addr_q  <= lsu_addr_i;
      we_q    <= lsu_we_i;
      size_q  <= lsu_size_i;
      sign_q  <= lsu_sign_ext_i;
      wdata_q <= lsu_wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      second_q <= 1'b0;
      lo_q     <= '0;
    end else begin
      case (state)
        IDLE: if (lsu_en_i) state <= data_gnt_i ? RESP : REQ;
        REQ:  if (data_gnt_i) state <= RESP;
        RESP: begin
          if (data_rvalid_i) begin
            if (!last_resp) begin
              lo_q     <= data_rdata_i;
              second_q <= 1'b1;
              state    <= REQ;
            end else begin
              second_q <= 1'b0;
              state    <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: aligned, sub-word, delayed-grant, split
// and wrapping accesses, stray handshakes and mid-transaction reset.
module tb_load_store_unit;
  import riscv_defines::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lsu_en = 1'b0;
  logic        lsu_we = 1'b0;
  logic [1:0]  lsu_size = 2'b00;
  logic        lsu_sign = 1'b0;
  logic [31:0] lsu_addr = '0;
  logic [31:0] lsu_wdata = '0;
  logic [31:0] lsu_rdata;
  logic        lsu_done;
  logic        data_req;
  logic        data_gnt = 1'b0;
  logic [31:0] data_addr;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_wdata;
  logic        data_rvalid = 1'b0;
  logic [31:0] data_rdata = '0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .lsu_en_i       (lsu_en),
    .lsu_we_i       (lsu_we),
    .lsu_size_i     (lsu_size),
    .lsu_sign_ext_i (lsu_sign),
    .lsu_addr_i     (lsu_addr),
    .lsu_wdata_i    (lsu_wdata),
    .lsu_rdata_o    (lsu_rdata),
    .lsu_done_o     (lsu_done),
    .data_req_o     (data_req),
    .data_gnt_i     (data_gnt),
    .data_addr_o    (data_addr),
    .data_we_o      (data_we),
    .data_be_o      (data_be),
    .data_wdata_o   (data_wdata),
    .data_rvalid_i  (data_rvalid),
    .data_rdata_i   (data_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata);
    lsu_en = 1'b1; lsu_we = we; lsu_size = size; lsu_sign = sgn;
    lsu_addr = addr; lsu_wdata = wdata;
  endtask

  task automatic bus_chk(input string tag, input logic [31:0] eaddr, input logic [3:0] ebe,
                         input logic ewe, input logic [31:0] ewdata);
    chk({tag, ".req"}, 32'(data_req), 32'd1);
    chk({tag, ".addr"}, data_addr, eaddr);
    chk({tag, ".be"}, 32'(data_be), 32'(ebe));
    chk({tag, ".we"}, 32'(data_we), 32'(ewe));
    chk({tag, ".wdata"}, data_wdata, ewdata);
    chk({tag, ".done0"}, 32'(lsu_done), 32'd0);
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, ".idle_req"}, 32'(data_req), 32'd0);
    chk({tag, ".idle_done"}, 32'(lsu_done), 32'd0);
    chk({tag, ".idle_rdata"}, lsu_rdata, 32'd0);
    chk({tag, ".idle_addr"}, data_addr, 32'd0);
  endtask

  // Unsplit access with gdly grant-less cycles before the grant.
  task automatic single(input string tag, input logic we, input logic [1:0] size,
                        input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                        input int gdly, input logic [31:0] rd, input logic [31:0] eaddr,
                        input logic [3:0] ebe, input logic [31:0] ewdata,
                        input logic [31:0] erdata);
    issue(we, size, sgn, addr, wdata);
    for (int c = 0; c <= gdly; c++) begin
      data_gnt = (c == gdly);
      @(negedge clk);
      bus_chk($sformatf("%s.c%0d", tag, c), eaddr, ebe, we, ewdata);
      step();
    end
    data_gnt = 1'b0; data_rvalid = 1'b1; data_rdata = rd; lsu_en = 1'b0;
    @(negedge clk);
    chk({tag, ".done"}, 32'(lsu_done), 32'd1);
    chk({tag, ".rdata"}, lsu_rdata, erdata);
    chk({tag, ".resp_req"}, 32'(data_req), 32'd0);
    step();
    data_rvalid = 1'b0;
    @(negedge clk);
    idle_chk(tag);
    step();
  endtask

  // Split access at best-case timing; lsu_en drops after part 1 is granted.
  task automatic split_x(input string tag, input logic we, input logic [1:0] size,
                         input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] lo, input logic [31:0] hi,
                         input logic [31:0] a1, input logic [3:0] b1,
                         input logic [31:0] a2, input logic [3:0] b2,
                         input logic [31:0] ewdata, input logic [31:0] erdata);
    issue(we, size, sgn, addr, wdata);
    data_gnt = 1'b1;
    @(negedge clk);
    bus_chk({tag, ".p1"}, a1, b1, we, ewdata);
    step();
    lsu_en = 1'b0; data_gnt = 1'b0; data_rvalid = 1'b1; data_rdata = lo;
    @(negedge clk);
    chk({tag, ".r1_done"}, 32'(lsu_done), 32'd0);
    chk({tag, ".r1_req"}, 32'(data_req), 32'd0);
    step();
    data_rvalid = 1'b0; data_gnt = 1'b1; data_rdata = '0;
    @(negedge clk);
    bus_chk({tag, ".p2"}, a2, b2, we, ewdata);
    step();
    data_gnt = 1'b0; data_rvalid = 1'b1; data_rdata = hi;
    @(negedge clk);
    chk({tag, ".done"}, 32'(lsu_done), 32'd1);
    chk({tag, ".rdata"}, lsu_rdata, erdata);
    step();
    data_rvalid = 1'b0;
    @(negedge clk);
    idle_chk(tag);
    step();
  endtask

  initial begin
    #2;
    @(negedge clk);
    idle_chk("reset");
    chk("reset.be", 32'(data_be), 32'd0);
    chk("reset.wdata", data_wdata, 32'd0);
    step();
    rst_n = 1'b1;
    step();

    single("lw", 1'b0, LSU_SIZE_W, 1'b0, 32'h100, 32'h0, 0, 32'hDEADBEEF,
           32'h100, 4'b1111, 32'h0, 32'hDEADBEEF);
    single("lb", 1'b0, LSU_SIZE_B, 1'b1, 32'h103, 32'h0, 0, 32'h80FFFFFF,
           32'h100, 4'b1000, 32'h0, 32'hFFFFFF80);
    single("lbu", 1'b0, LSU_SIZE_B, 1'b0, 32'h103, 32'h0, 0, 32'h80FFFFFF,
           32'h100, 4'b1000, 32'h0, 32'h00000080);
    single("sh", 1'b1, LSU_SIZE_H, 1'b0, 32'h202, 32'h1234ABCD, 3, 32'hFFFFFFFF,
           32'h200, 4'b1100, 32'hABCD1234, 32'h0);
    single("lhu", 1'b0, LSU_SIZE_H, 1'b0, 32'h306, 32'h0, 1, 32'hA5C3_7788,
           32'h304, 4'b1100, 32'h0, 32'h0000A5C3);
    split_x("lw_mis", 1'b0, LSU_SIZE_W, 1'b0, 32'h0FD, 32'h0, 32'h44332211, 32'h88776655,
            32'h0FC, 4'b1110, 32'h100, 4'b0001, 32'h0, 32'h55443322);
    split_x("lh_wrap", 1'b0, LSU_SIZE_H, 1'b1, 32'hFFFFFFFF, 32'h0, 32'h11223344, 32'h55667788,
            32'hFFFFFFFC, 4'b1000, 32'h0, 4'b0001, 32'h0, 32'hFFFF8811);
    split_x("sw_mis", 1'b1, 2'b11, 1'b0, 32'h40E, 32'hAABBCCDD, 32'h0, 32'h0,
            32'h40C, 4'b1100, 32'h410, 4'b0011, 32'hCCDDAABB, 32'h0);

    // Stray grant and response while idle must not start anything.
    data_gnt = 1'b1; data_rvalid = 1'b1; data_rdata = 32'h12345678;
    @(negedge clk);
    idle_chk("stray");
    step();
    data_gnt = 1'b0; data_rvalid = 1'b0;
    single("after_stray", 1'b0, LSU_SIZE_W, 1'b0, 32'h500, 32'h0, 0, 32'hCAFEF00D,
           32'h500, 4'b1111, 32'h0, 32'hCAFEF00D);

    // Split load interrupted by reset in the part-2 response phase.
    issue(1'b0, LSU_SIZE_W, 1'b0, 32'h0FD, 32'h0);
    data_gnt = 1'b1;
    step();
    data_gnt = 1'b0; data_rvalid = 1'b1; data_rdata = 32'h44332211;
    step();
    data_rvalid = 1'b0; data_gnt = 1'b1;
    step();
    data_gnt = 1'b0;
    rst_n = 1'b0;
    data_rvalid = 1'b1; data_rdata = 32'h88776655;
    @(negedge clk);
    idle_chk("rst_mid");
    chk("rst_mid.be", 32'(data_be), 32'd0);
    chk("rst_mid.we", 32'(data_we), 32'd0);
    chk("rst_mid.wdata", data_wdata, 32'd0);
    step();
    data_rvalid = 1'b0; lsu_en = 1'b0;
    rst_n = 1'b1;
    step();
    single("post_rst", 1'b0, LSU_SIZE_W, 1'b0, 32'h100, 32'h0, 0, 32'h01020304,
           32'h100, 4'b1111, 32'h0, 32'h01020304);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
